// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared state encoding and default sizing for the UART TX arbiter.
package uart_tx_arb_pkg;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_TIMEOUT_CYC = 4096;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_DONE,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
// Searches from last_grant+1 upward, wrapping; the first valid requester in that order wins.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int W     = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [W-1:0]     last_grant,
    output logic             any_valid,
    output logic [W-1:0]     winner
);

    int         idx;
    logic [W-1:0] sel;

    // Walk the search order backwards so the earliest candidate is written last.
    always_comb begin
        winner = '0;
        idx    = 0;
        sel    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(last_grant) + 1 + k) % N_REQ;
            sel = W'(idx);
            if (req_valid[sel]) winner = sel;
        end
    end

    assign any_valid = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding one UART transmitter from N_REQ byte requesters.
// Define UART_TX_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog with a tx_timeout pulse.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           req_done,
    output logic                       tx_start,
    output logic [7:0]                 tx_din,
    input  logic                       tx_done_tick,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic                       tx_timeout
`endif
);

    localparam int GW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported configuration");
    end

    arb_state_t       state, state_n;
    logic [GW-1:0]    last_grant, grant_q, winner;
    logic             any_valid, grant_fire, timed_out;
    logic [7:0]       din_q, sel_data;
    logic [N_REQ-1:0] one_win, one_grant;

    uart_rr_pick #(.N_REQ(N_REQ), .W(GW)) u_pick (
        .req_valid (req_valid),
        .last_grant(last_grant),
        .any_valid (any_valid),
        .winner    (winner)
    );

    // The winner is re-picked live in GRANT, so a requester that dropped out is skipped.
    assign grant_fire = (state == GRANT) && any_valid;
    assign sel_data   = req_data[{winner, 3'b000} +: 8];
    assign one_win    = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
    assign one_grant  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

    assign tx_start  = grant_fire;
    assign req_ready = grant_fire ? one_win : '0;
    assign tx_din    = grant_fire ? sel_data : din_q;
    assign grant_id  = grant_fire ? winner : grant_q;
    assign busy      = state != IDLE;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= (state == WAIT_DONE) ? cnt + 1'b1 : '0;
    end

    assign timed_out  = (state == WAIT_DONE) && !tx_done_tick && (cnt == CW'(TIMEOUT_CYC - 1));
    assign tx_timeout = timed_out;
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        req_done = '0;
        case (state)
            IDLE:      state_n = |req_valid ? GRANT : IDLE;
            GRANT:     state_n = any_valid ? WAIT_DONE : IDLE;
            WAIT_DONE: begin
                req_done = tx_done_tick ? one_grant : '0;
                state_n  = (tx_done_tick || timed_out) ? RELEASE : WAIT_DONE;
            end
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(N_REQ - 1);
            grant_q    <= '0;
            din_q      <= '0;
        end else begin
            state <= state_n;
            if (grant_fire) begin
                last_grant <= winner;
                grant_q    <= winner;
                din_q      <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven and scoreboarded bench for uart_tx_arbiter (N_REQ=4).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready, req_done;
    logic        tx_start, busy;
    logic [7:0]  tx_din;
    logic        tx_done_tick = 1'b0;
    logic [1:0]  grant_id;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic        tx_timeout;
`endif

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .req_done    (req_done),
        .tx_start    (tx_start),
        .tx_din      (tx_din),
        .tx_done_tick(tx_done_tick),
        .busy        (busy),
        .grant_id    (grant_id)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .tx_timeout  (tx_timeout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] din;
    } exp_t;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  id;
        logic [7:0]  din;
    } vec_t;

    exp_t       exp_q[$];
    logic [1:0] done_q[$];
    exp_t       e;
    logic [1:0] d;
    vec_t       vecs[6];
    int n_chk = 0, n_pass = 0, n_start = 0, n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every grant and every done pulse is matched against the queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                n_start++;
                if (exp_q.size() == 0) chk("unexpected_start", {30'd0, grant_id}, 32'hFFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("grant_id", {30'd0, grant_id}, {30'd0, e.id});
                    chk("tx_din", {24'd0, tx_din}, {24'd0, e.din});
                    chk("req_ready", {28'd0, req_ready}, 32'd1 << e.id);
                end
            end else if (req_ready != 0) chk("stray_ready", {28'd0, req_ready}, 32'd0);
            if (req_done != 0) begin
                n_done++;
                if (done_q.size() == 0) chk("unexpected_done", {28'd0, req_done}, 32'd0);
                else begin
                    d = done_q.pop_front();
                    chk("req_done", {28'd0, req_done}, 32'd1 << d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        @(negedge clk);
        while (!tx_start && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!tx_start) chk("start_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tx_done_tick = 1'b0;
        #1;
        chk("rst_outputs", {12'd0, tx_start, req_ready, req_done, busy, grant_id, tx_din}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic do_frame(input logic [3:0] v, input logic [31:0] dat,
                            input logic [1:0] id, input logic [7:0] din);
        int lat;
        int dn;
        dn = n_done;
        req_valid = v;
        req_data  = dat;
        exp_q.push_back('{id: id, din: din});
        wait_start(lat);
        chk("start_latency", lat, 1);
        step();
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        chk("din_hold", {24'd0, tx_din}, {24'd0, din});
        chk("busy_wait", {31'd0, busy}, 32'd1);
        step();
        done_q.push_back(id);
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        step();
        chk("frame_done_count", n_done - dn, 1);
        chk("idle_after_release", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, s0, d0, rdy2;
        vecs[0] = '{valid: 4'b0010, data: 32'h0000_A500, id: 2'd1, din: 8'hA5};
        vecs[1] = '{valid: 4'b1111, data: 32'h4433_2211, id: 2'd2, din: 8'h33};
        vecs[2] = '{valid: 4'b0011, data: 32'h0000_7E81, id: 2'd0, din: 8'h81};
        vecs[3] = '{valid: 4'b1001, data: 32'hC300_005A, id: 2'd3, din: 8'hC3};
        vecs[4] = '{valid: 4'b0100, data: 32'h0096_0000, id: 2'd2, din: 8'h96};
        vecs[5] = '{valid: 4'b0001, data: 32'h0000_000F, id: 2'd0, din: 8'h0F};

        do_reset();
        chk("reset_idle", {12'd0, tx_start, req_ready, req_done, busy, grant_id, tx_din}, 32'd0);

        // A done tick while idle must be ignored.
        tx_done_tick = 1'b1;
        @(negedge clk);
        chk("idle_tick_done", {28'd0, req_done}, 32'd0);
        step();
        tx_done_tick = 1'b0;
        chk("idle_tick_busy", {31'd0, busy}, 32'd0);
        step();
        chk("idle_tick_busy2", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) do_frame(vecs[i].valid, vecs[i].data, vecs[i].id, vecs[i].din);

        // All four continuously valid: strict rotation 0,1,2,3,0.
        do_reset();
        s0 = n_start;
        d0 = n_done;
        req_valid = 4'hF;
        req_data  = 32'h4433_2211;
        for (int k = 0; k < 5; k++) exp_q.push_back('{id: 2'(k % 4), din: 8'(8'h11 * ((k % 4) + 1))});
        for (int k = 0; k < 5; k++) begin
            wait_start(lat);
            if (k == 0) chk("rotate_latency", lat, 1);
            step();
            step();
            done_q.push_back(2'(k % 4));
            tx_done_tick = 1'b1;
            if (k == 4) req_valid = '0;
            step();
            tx_done_tick = 1'b0;
        end
        step();
        step();
        chk("rotate_starts", n_start - s0, 5);
        chk("rotate_dones", n_done - d0, 5);
        chk("rotate_idle", {31'd0, busy}, 32'd0);

        // Requester 2 withdraws as GRANT begins; requester 3 must win instead.
        req_data  = 32'hD4C3_B2A1;
        req_valid = 4'b1100;
        exp_q.push_back('{id: 2'd3, din: 8'hD4});
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("drop_start", {31'd0, tx_start}, 32'd1);
        rdy2 = int'(req_ready[2]);
        chk("drop_no_ready2", rdy2, 0);
        step();
        req_valid = '0;
        step();
        done_q.push_back(2'd3);
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        step();
        step();

        // Reset during WAIT_DONE abandons the frame; next grant restarts at requester 0.
        req_data  = 32'h0000_6600;
        req_valid = 4'b0010;
        exp_q.push_back('{id: 2'd1, din: 8'h66});
        wait_start(lat);
        step();
        req_valid = '0;
        step();
        d0 = n_done;
        do_reset();
        chk("rst_mid_no_done", n_done - d0, 0);
        do_frame(4'b1111, 32'h1122_3344, 2'd0, 8'h44);

`ifdef UART_TX_ARB_TIMEOUT_EN
        d0 = n_done;
        req_data  = 32'h0055_0000;
        req_valid = 4'b0100;
        exp_q.push_back('{id: 2'd2, din: 8'h55});
        wait_start(lat);
        lat = 0;
        step();
        req_valid = '0;
        @(negedge clk);
        lat = 1;
        while (!tx_timeout && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("timeout_cycles", lat, 16);
        chk("timeout_no_done", {28'd0, req_done}, 32'd0);
        step();
        step();
        chk("timeout_idle", {31'd0, busy}, 32'd0);
        chk("timeout_done_count", n_done - d0, 0);
`endif

        step();
        chk("exp_q_empty", exp_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
